// File: rtl/weight_tile_loader_pkg.sv
// Shared types for the weight tile loader: row/tile layouts at the default
// array geometry and the loader FSM state encoding.
package globals;

    localparam int DEF_SZI     = 8;
    localparam int DEF_SZJ     = 8;
    localparam int DEF_B_WIDTH = 8;

    typedef logic [DEF_SZJ*DEF_B_WIDTH-1:0] WeightRow;
    typedef WeightRow [DEF_SZI-1:0]          WeightTile;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } TileLoaderState;

endpackage

// File: rtl/weight_tile_loader_buf.sv
// Double-buffered tile storage: rows are written one at a time into the shadow
// copy, and a swap moves the whole shadow tile into the active copy at once.
module weight_tile_buf #(
    parameter int SZI     = 8,
    parameter int SZJ     = 8,
    parameter int B_WIDTH = 8,
    parameter int IDX_W   = (SZI > 1) ? $clog2(SZI) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [SZJ*B_WIDTH-1:0]       wr_data,
    input  logic                         swap,
    output logic [SZI*SZJ*B_WIDTH-1:0]   weights
);

    localparam int ROW_W = SZJ * B_WIDTH;

    logic [SZI-1:0][ROW_W-1:0] shadow;
    logic [SZI-1:0][ROW_W-1:0] active;

    // NOTE: both copies are reset because weights must read as zero after reset;
    // storage that is always overwritten before use would not need a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) shadow[wr_idx] <= wr_data;
            if (swap)  active <= shadow;
        end
    end

    assign weights = active;

endmodule

// File: rtl/weight_tile_loader.sv
// Pops weight rows from the FIFO into a shadow tile and swaps complete tiles to
// the GEMM array. Optional stall statistics: WEIGHT_TILE_LOADER_STATS_EN.
module weight_tile_loader
    import globals::*;
#(
    parameter int SZI     = 8,
    parameter int SZJ     = 8,
    parameter int B_WIDTH = 8,
    parameter int CNT_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CNT_W-1:0]            total_tiles,
    input  logic [SZJ*B_WIDTH-1:0]      fifo_q,
    input  logic                        fifo_empty,
    output logic                        fifo_rdreq,
    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic [SZI*SZJ*B_WIDTH-1:0]  weights,
    output logic                        active_valid,
    output logic                        shadow_ready,
    output logic                        loaded_all,
    output logic                        busy
`ifdef WEIGHT_TILE_LOADER_STATS_EN
    ,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic [CNT_W-1:0]            fifo_starve_cycles
`endif
);

    localparam int RCNT_W = $clog2(SZI + 1);
    localparam int IDX_W  = (SZI > 1) ? $clog2(SZI) : 1;
    localparam logic [RCNT_W-1:0] ROWS_FULL = RCNT_W'(SZI);
    localparam logic [RCNT_W-1:0] ROW_LAST  = RCNT_W'(SZI - 1);

    TileLoaderState state, state_next;

    logic [RCNT_W-1:0] rows_issued;
    logic [RCNT_W-1:0] rows_captured;
    logic [CNT_W-1:0]  tiles_swapped;
    logic [CNT_W-1:0]  total_latched;
    logic              rdreq_d;
    logic              zero_run_q;
    logic              start_run;
    logic              capture;
    logic              last_tile;

    assign last_tile = (tiles_swapped + CNT_W'(1)) == total_latched;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        fifo_rdreq = 1'b0;
        swap_ack   = 1'b0;
        capture    = 1'b0;
        start_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start && total_tiles != '0) begin
                    start_run  = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                fifo_rdreq = !fifo_empty && (rows_issued < ROWS_FULL);
                capture    = rdreq_d;
                if (rdreq_d && rows_captured == ROW_LAST) state_next = FULL;
            end
            FULL: begin
                if (swap_req) begin
                    swap_ack   = 1'b1;
                    state_next = last_tile ? IDLE : FILL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign shadow_ready = (state == FULL);
    assign busy         = (state != IDLE);
    // A zero-tile run reports completion one cycle after its start pulse.
    assign loaded_all   = (swap_ack && last_tile) || zero_run_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rows_issued   <= '0;
            rows_captured <= '0;
            tiles_swapped <= '0;
            total_latched <= '0;
            rdreq_d       <= 1'b0;
            zero_run_q    <= 1'b0;
            active_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            rdreq_d    <= fifo_rdreq;
            zero_run_q <= (state == IDLE) && start && (total_tiles == '0);
            if (start_run) begin
                rows_issued   <= '0;
                rows_captured <= '0;
                tiles_swapped <= '0;
                total_latched <= total_tiles;
                active_valid  <= 1'b0;
            end else if (swap_ack) begin
                rows_issued   <= '0;
                rows_captured <= '0;
                tiles_swapped <= tiles_swapped + CNT_W'(1);
                active_valid  <= 1'b1;
            end else begin
                if (fifo_rdreq) rows_issued   <= rows_issued + RCNT_W'(1);
                if (capture)    rows_captured <= rows_captured + RCNT_W'(1);
            end
        end
    end

    weight_tile_buf #(
        .SZI     (SZI),
        .SZJ     (SZJ),
        .B_WIDTH (B_WIDTH),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_idx  (rows_captured[IDX_W-1:0]),
        .wr_data (fifo_q),
        .swap    (swap_ack),
        .weights (weights)
    );

`ifdef WEIGHT_TILE_LOADER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || start_run) begin
            stall_cycles       <= '0;
            fifo_starve_cycles <= '0;
        end else begin
            if (swap_req && !swap_ack)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (state == FILL && rows_issued < ROWS_FULL && fifo_empty)
                fifo_starve_cycles <= fifo_starve_cycles + CNT_W'(1);
        end
    end
`endif

endmodule
